// File: rtl/interrupt_controller_pkg.sv
// Shared definitions for the interrupt controller: FSM encodings, default
// vector map and the index-width helper used by the top and its encoder.
package interrupt_controller_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    REQUEST = 2'b01,
    SERVICE = 2'b10
  } state_t;

  localparam logic [15:0] DEFAULT_VECTOR_BASE   = 16'h0002;
  localparam int          DEFAULT_VECTOR_STRIDE = 2;

  // Index width for n sources, never narrower than one bit.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/interrupt_controller_priority_encoder.sv
// Combinational fixed-priority encoder: the lowest set request bit wins.
// Kept generic so exception logic in the core can reuse it.
module priority_encoder #(
  parameter int WIDTH = 4,
  parameter int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic [WIDTH-1:0] i_req,
  output logic [IDX_W-1:0] o_idx,
  output logic             o_valid
);

  // NOTE: every output gets a default first, so no path through the block
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    // Scan high to low so the lowest set index is the last one written.
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_idx   = IDX_W'(i);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/interrupt_controller.sv
// Multi-source interrupt controller: latches edge/level requests, picks the
// lowest enabled index, and hands one request to the core until RTI.
module interrupt_controller
  import interrupt_controller_pkg::*;
#(
  parameter int                   NUM_IRQ       = 4,
  parameter int                   VEC_WIDTH     = 16,
  parameter logic [VEC_WIDTH-1:0] VECTOR_BASE   = VEC_WIDTH'(DEFAULT_VECTOR_BASE),
  parameter int                   VECTOR_STRIDE = DEFAULT_VECTOR_STRIDE,
  parameter logic [NUM_IRQ-1:0]   EDGE_MASK     = '1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_IRQ-1:0]              irq_in,
  input  logic                            mask_wr_en,
  input  logic [NUM_IRQ-1:0]              mask_wr_data,
  input  logic                            int_ack,
  input  logic                            int_rti,
  output logic                            int_req,
  output logic [VEC_WIDTH-1:0]            int_vector,
  output logic [id_width(NUM_IRQ)-1:0]    int_id,
  output logic                            in_service,
  output logic [NUM_IRQ-1:0]              pending
);

  localparam int ID_W = id_width(NUM_IRQ);

  state_t               r_state;
  state_t               w_state_next;
  logic [NUM_IRQ-1:0]   r_prev_irq;
  logic [NUM_IRQ-1:0]   r_pending;
  logic [NUM_IRQ-1:0]   r_mask;
  logic                 r_int_req;
  logic [VEC_WIDTH-1:0] r_int_vector;
  logic [ID_W-1:0]      r_int_id;
  logic                 r_in_service;

  logic [NUM_IRQ-1:0]   w_set;
  logic [NUM_IRQ-1:0]   w_clr;
  logic [NUM_IRQ-1:0]   w_eligible;
  logic [ID_W-1:0]      w_win_idx;
  logic                 w_win_valid;
  logic [VEC_WIDTH-1:0] w_win_vector;
  logic                 w_take;
  logic                 w_ack;
  logic                 w_rti;

  // Edge sources fire on a 0->1 transition; level sources fire while high.
  assign w_set        = irq_in & ((EDGE_MASK & ~r_prev_irq) | ~EDGE_MASK);
  assign w_clr        = w_ack ? (NUM_IRQ'(1) << r_int_id) : '0;
  assign w_eligible   = r_pending & r_mask;
  assign w_win_vector = VECTOR_BASE + VEC_WIDTH'(w_win_idx) * VEC_WIDTH'(VECTOR_STRIDE);

  priority_encoder #(
    .WIDTH (NUM_IRQ),
    .IDX_W (ID_W)
  ) u_prio (
    .i_req   (w_eligible),
    .o_idx   (w_win_idx),
    .o_valid (w_win_valid)
  );

  always_comb begin
    w_state_next = r_state;
    w_take       = 1'b0;
    w_ack        = 1'b0;
    w_rti        = 1'b0;
    case (r_state)
      IDLE: if (w_win_valid) begin
        w_state_next = REQUEST;
        w_take       = 1'b1;
      end
      REQUEST: if (int_ack) begin
        w_state_next = SERVICE;
        w_ack        = 1'b1;
      end
      SERVICE: if (int_rti) begin
        w_state_next = IDLE;
        w_rti        = 1'b1;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_prev_irq   <= '0;
      r_pending    <= '0;
      r_mask       <= '1;
      r_int_req    <= 1'b0;
      r_int_vector <= '0;
      r_int_id     <= '0;
      r_in_service <= 1'b0;
    end else begin
      r_prev_irq <= irq_in;
      // A set landing on the same cycle as the ack clear wins.
      r_pending  <= (r_pending & ~w_clr) | w_set;
      if (mask_wr_en) r_mask <= mask_wr_data;
      if (w_take) begin
        r_int_req    <= 1'b1;
        r_int_id     <= w_win_idx;
        r_int_vector <= w_win_vector;
      end
      if (w_ack) begin
        r_int_req    <= 1'b0;
        r_in_service <= 1'b1;
      end
      if (w_rti) r_in_service <= 1'b0;
    end
  end

  assign int_req    = r_int_req;
  assign int_vector = r_int_vector;
  assign int_id     = r_int_id;
  assign in_service = r_in_service;
  assign pending    = r_pending;

endmodule
